// File: rtl/piso_pkg.sv
// Shared types and limits for the parallel-in/serial-out serializer.
package piso_pkg;

  localparam int PISO_MAX_WIDTH = 64;

  // PARITY is only reachable when the parity build option is enabled.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

endpackage

// File: rtl/piso_serializer_if.sv
// Load/ready word handshake plus serial frame outputs of the serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             load;
  logic             lsb_first;
  logic             ready;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  modport master (
    output din, load, lsb_first,
    input  ready, dout, dout_valid, busy, done
  );

  modport slave (
    input  din, load, lsb_first,
    output ready, dout, dout_valid, busy, done
  );
endinterface

// File: rtl/piso_bit_counter.sv
// Frame bit counter: clear-to-1 on accept, counts up to TERM and holds there.
module piso_bit_counter #(
  parameter int               CNT_W = 4,
  parameter logic [CNT_W-1:0] TERM  = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);
  logic [CNT_W-1:0] r_count;

  // Clearing loads 1 because the accepting edge already emits the first bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= CNT_W'(1);
    end else if (i_en && !o_tc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == TERM);
endmodule

// File: rtl/piso_serializer.sv
// WIDTH-bit parallel-in/serial-out serializer with per-word bit order selection.
// Build option PISO_PARITY_EN appends an even-parity bit to every frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  piso_serializer_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  if (WIDTH < 2 || WIDTH > PISO_MAX_WIDTH) begin : g_width_check
    $error("piso_serializer: WIDTH must lie in 2..64");
  end

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_shift;
  logic             r_lsb_first;
  logic             r_dout;
  logic             r_dout_valid;
  logic             w_tc;
  logic             w_accept;
  logic             w_shift_en;
  logic             w_ready;
  logic             w_busy;
  logic             w_done;
`ifdef PISO_PARITY_EN
  logic             r_parity;
`endif

  piso_bit_counter #(
    .CNT_W (CNT_W),
    .TERM  (CNT_W'(WIDTH))
  ) u_bit_counter (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_accept),
    .i_en    (w_shift_en),
    .o_tc    (w_tc)
  );

  assign w_accept   = bus.load & w_ready;
  assign w_shift_en = (r_state == SHIFT) & ~w_tc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ready never depends on load, so accept has no combinational loop.
  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    w_done       = 1'b0;
    w_busy       = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (bus.load) w_next_state = SHIFT;
      end
      SHIFT: begin
        if (w_tc) begin
`ifdef PISO_PARITY_EN
          w_next_state = PARITY;
`else
          w_ready      = 1'b1;
          w_done       = 1'b1;
          w_next_state = bus.load ? SHIFT : IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        w_ready      = 1'b1;
        w_done       = 1'b1;
        w_next_state = bus.load ? SHIFT : IDLE;
      end
`endif
      default: w_next_state = IDLE;
    endcase
  end

  // The register always presents the next bit to send at the end selected by r_lsb_first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift      <= '0;
      r_lsb_first  <= 1'b0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
`ifdef PISO_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else if (w_accept) begin
      r_lsb_first  <= bus.lsb_first;
      r_dout       <= bus.lsb_first ? bus.din[0] : bus.din[WIDTH-1];
      r_shift      <= bus.lsb_first ? (bus.din >> 1) : (bus.din << 1);
      r_dout_valid <= 1'b1;
`ifdef PISO_PARITY_EN
      r_parity     <= ^bus.din;
`endif
    end else if (w_shift_en) begin
      r_dout  <= r_lsb_first ? r_shift[0] : r_shift[WIDTH-1];
      r_shift <= r_lsb_first ? (r_shift >> 1) : (r_shift << 1);
`ifdef PISO_PARITY_EN
    end else if (r_state == SHIFT) begin
      r_dout <= r_parity;
`endif
    end else begin
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
    end
  end

  assign bus.ready      = w_ready;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
endmodule
